// File: rtl/iq_pkg.sv
// iq_pkg: shared sizes and the issue-queue entry record
package iq_pkg;
  localparam int NUM_PHYS_REGS = 64;
  localparam int PREG_W = $clog2(NUM_PHYS_REGS);
  localparam int IQ_DEPTH = 16;
  localparam int PAYLOAD_W = 32;
  localparam int IDX_W = $clog2(IQ_DEPTH);
  localparam int CNT_W = $clog2(IQ_DEPTH) + 1;
  typedef struct packed {
    logic valid;
    logic uses_rs;
    logic uses_rt;
    logic uses_rd;
    logic [PREG_W-1:0] rs_phys;
    logic [PREG_W-1:0] rt_phys;
    logic [PREG_W-1:0] rd_phys;
    logic rs_rdy;
    logic rt_rdy;
    logic [PAYLOAD_W-1:0] payload;
  } iq_entry_t;
endpackage

// File: rtl/issue_scheduler_if.sv
// issue_scheduler_if: rename/execute/writeback signals of the issue scheduler
interface issue_scheduler_if;
  import iq_pkg::*;
  logic alloc_valid;
  logic alloc_ready;
  logic alloc_uses_rs;
  logic alloc_uses_rt;
  logic alloc_uses_rd;
  logic [PREG_W-1:0] alloc_rs_phys;
  logic [PREG_W-1:0] alloc_rt_phys;
  logic [PREG_W-1:0] alloc_rd_phys;
  logic [PAYLOAD_W-1:0] alloc_payload;
  logic issue_valid;
  logic issue_ready;
  logic [PREG_W-1:0] issue_rs_phys;
  logic [PREG_W-1:0] issue_rt_phys;
  logic [PREG_W-1:0] issue_rd_phys;
  logic issue_uses_rd;
  logic [PAYLOAD_W-1:0] issue_payload;
  logic wb_valid;
  logic [PREG_W-1:0] wb_phys;
  logic flush;
  logic [CNT_W-1:0] count;
  modport master (
    output alloc_valid, alloc_uses_rs, alloc_uses_rt, alloc_uses_rd,
    output alloc_rs_phys, alloc_rt_phys, alloc_rd_phys, alloc_payload,
    output issue_ready, wb_valid, wb_phys, flush,
    input alloc_ready, issue_valid, issue_rs_phys, issue_rt_phys, issue_rd_phys,
    input issue_uses_rd, issue_payload, count
  );
  modport slave (
    input alloc_valid, alloc_uses_rs, alloc_uses_rt, alloc_uses_rd,
    input alloc_rs_phys, alloc_rt_phys, alloc_rd_phys, alloc_payload,
    input issue_ready, wb_valid, wb_phys, flush,
    output alloc_ready, issue_valid, issue_rs_phys, issue_rt_phys, issue_rd_phys,
    output issue_uses_rd, issue_payload, count
  );
endinterface

// File: rtl/preg_scoreboard.sv
// preg_scoreboard: per-physical-register ready bits with writeback bypass lookups
module preg_scoreboard
  import iq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_en,
  input  logic [PREG_W-1:0] clr_tag,
  input  logic              set_en,
  input  logic [PREG_W-1:0] set_tag,
  input  logic [PREG_W-1:0] rs_tag,
  input  logic [PREG_W-1:0] rt_tag,
  output logic              rs_rdy,
  output logic              rt_rdy
);
  logic [NUM_PHYS_REGS-1:0] rdy;
  assign rs_rdy = rdy[rs_tag] || (set_en && set_tag == rs_tag);
  assign rt_rdy = rdy[rt_tag] || (set_en && set_tag == rt_tag);
  // clear is written last so a newer producer's clear beats a same-tag writeback
  always_ff @(posedge clk) begin
    if (rst) rdy <= '1;
    else begin
      if (set_en) rdy[set_tag] <= 1'b1;
      if (clr_en) rdy[clr_tag] <= 1'b0;
    end
  end
endmodule

// File: rtl/issue_scheduler.sv
// issue_scheduler: single-issue oldest-ready-first out-of-order issue queue
module issue_scheduler
  import iq_pkg::*;
(
  input logic clk,
  input logic rst,
  issue_scheduler_if.slave bus
);
  iq_entry_t q [IQ_DEPTH];
  logic [IQ_DEPTH-1:0] older [IQ_DEPTH];
  logic [IQ_DEPTH-1:0] cand;
  logic [IDX_W-1:0] sel, free;
  logic [CNT_W-1:0] cnt;
  logic hit, alloc, issue, sb_rs, sb_rt;
  assign alloc = bus.alloc_valid && bus.alloc_ready;
  assign issue = hit && bus.issue_ready;
  assign bus.alloc_ready = cnt < CNT_W'(IQ_DEPTH) && !bus.flush;
  assign bus.issue_valid = hit;
  assign bus.issue_rs_phys = hit ? q[sel].rs_phys : '0;
  assign bus.issue_rt_phys = hit ? q[sel].rt_phys : '0;
  assign bus.issue_rd_phys = hit ? q[sel].rd_phys : '0;
  assign bus.issue_uses_rd = hit && q[sel].uses_rd;
  assign bus.issue_payload = hit ? q[sel].payload : '0;
  assign bus.count = cnt;
  preg_scoreboard sb (
    .clk(clk),
    .rst(rst),
    .clr_en(alloc && bus.alloc_uses_rd),
    .clr_tag(bus.alloc_rd_phys),
    .set_en(bus.wb_valid),
    .set_tag(bus.wb_phys),
    .rs_tag(bus.alloc_rs_phys),
    .rt_tag(bus.alloc_rt_phys),
    .rs_rdy(sb_rs),
    .rt_rdy(sb_rt)
  );
  // a candidate wins when it is older than every other candidate
  always_comb begin
    cand = '0;
    hit = 1'b0;
    sel = '0;
    for (int i = 0; i < IQ_DEPTH; i++) cand[i] = q[i].valid && q[i].rs_rdy && q[i].rt_rdy;
    for (int i = 0; i < IQ_DEPTH; i++)
      if (cand[i] && &(older[i] | ~cand | (IQ_DEPTH'(1) << i))) begin
        hit = 1'b1;
        sel = IDX_W'(i);
      end
  end
  // lowest-index empty slot receives the next allocation
  always_comb begin
    free = '0;
    for (int i = IQ_DEPTH - 1; i >= 0; i--) if (!q[i].valid) free = IDX_W'(i);
  end
  // entry array: wakeup, issue invalidate, allocate, flush, occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < IQ_DEPTH; i++) q[i].valid <= 1'b0;
      cnt <= '0;
    end else begin
      for (int i = 0; i < IQ_DEPTH; i++) begin
        if (bus.wb_valid && q[i].rs_phys == bus.wb_phys) q[i].rs_rdy <= 1'b1;
        if (bus.wb_valid && q[i].rt_phys == bus.wb_phys) q[i].rt_rdy <= 1'b1;
      end
      if (issue) q[sel].valid <= 1'b0;
      if (alloc)
        q[free] <= '{valid: 1'b1, uses_rs: bus.alloc_uses_rs, uses_rt: bus.alloc_uses_rt,
                     uses_rd: bus.alloc_uses_rd, rs_phys: bus.alloc_rs_phys,
                     rt_phys: bus.alloc_rt_phys, rd_phys: bus.alloc_rd_phys,
                     rs_rdy: !bus.alloc_uses_rs || sb_rs, rt_rdy: !bus.alloc_uses_rt || sb_rt,
                     payload: bus.alloc_payload};
      if (bus.flush) for (int i = 0; i < IQ_DEPTH; i++) q[i].valid <= 1'b0;
      cnt <= bus.flush ? '0 : cnt + CNT_W'(alloc) - CNT_W'(issue);
    end
  end
  // a new entry becomes younger than every other slot; stale bits of empty slots are never consulted
  always_ff @(posedge clk) begin
    if (alloc)
      for (int j = 0; j < IQ_DEPTH; j++) begin
        older[j][free] <= 1'b1;
        older[free][j] <= 1'b0;
      end
  end
endmodule

// File: tb/tb_issue_scheduler.sv
// tb_issue_scheduler: scoreboard-driven check of issue order, wakeup, full, flush and reset
module tb_issue_scheduler;
  import iq_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n = 0;
  int errs = 0;
  logic [31:0] exp_q [$];
  always #5 clk = ~clk;
  issue_scheduler_if bus ();
  issue_scheduler dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s got %0h want %0h at %0t", tag, got, want, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic alloc(input int rs, input int rt, input int rd, input logic [31:0] pl);
    bus.alloc_valid = 1'b1;
    bus.alloc_uses_rs = rs >= 0;
    bus.alloc_uses_rt = rt >= 0;
    bus.alloc_uses_rd = rd >= 0;
    bus.alloc_rs_phys = PREG_W'(rs < 0 ? 0 : rs);
    bus.alloc_rt_phys = PREG_W'(rt < 0 ? 0 : rt);
    bus.alloc_rd_phys = PREG_W'(rd < 0 ? 0 : rd);
    bus.alloc_payload = pl;
    tick();
    bus.alloc_valid = 1'b0;
  endtask
  task automatic wb(input int tag);
    bus.wb_valid = 1'b1;
    bus.wb_phys = PREG_W'(tag);
    tick();
    bus.wb_valid = 1'b0;
  endtask
  // every executed handshake must match the next expected payload
  always @(negedge clk) begin
    if (!rst && bus.issue_valid && bus.issue_ready) begin
      if (exp_q.size() == 0) chk("issue_extra", bus.issue_payload, 32'hdead_beef);
      else chk("issue_order", bus.issue_payload, exp_q.pop_front());
    end
  end
  initial begin
    bus.alloc_valid = 0; bus.alloc_uses_rs = 0; bus.alloc_uses_rt = 0; bus.alloc_uses_rd = 0;
    bus.alloc_rs_phys = 0; bus.alloc_rt_phys = 0; bus.alloc_rd_phys = 0; bus.alloc_payload = 0;
    bus.issue_ready = 0; bus.wb_valid = 0; bus.wb_phys = 0; bus.flush = 0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_alloc_ready", 32'(bus.alloc_ready), 1);
    chk("rst_issue_valid", 32'(bus.issue_valid), 0);
    chk("rst_payload", bus.issue_payload, 0);
    chk("rst_rd", 32'(bus.issue_rd_phys), 0);
    bus.issue_ready = 1'b1;
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    alloc(1, 2, -1, 1);
    chk("indep_first_valid", 32'(bus.issue_valid), 1);
    chk("indep_first_pl", bus.issue_payload, 1);
    alloc(3, -1, -1, 2);
    alloc(-1, 4, -1, 3);
    repeat (3) tick();
    chk("indep_drain", 32'(exp_q.size()), 0);
    exp_q.push_back(700);
    alloc(-1, -1, 10, 700);
    chk("ooo_x_rd", 32'(bus.issue_rd_phys), 10);
    chk("ooo_x_uses_rd", 32'(bus.issue_uses_rd), 1);
    alloc(-1, 10, -1, 701);
    exp_q.push_back(702);
    alloc(11, -1, -1, 702);
    repeat (3) tick();
    chk("ooo_a_waits", 32'(bus.issue_valid), 0);
    chk("ooo_count", 32'(bus.count), 1);
    exp_q.push_back(701);
    wb(10);
    chk("ooo_a_woken", 32'(bus.issue_valid), 1);
    tick();
    chk("ooo_drain", 32'(exp_q.size()), 0);
    exp_q.push_back(710);
    alloc(-1, -1, 20, 710);
    exp_q.push_back(711);
    bus.wb_valid = 1'b1;
    bus.wb_phys = 20;
    alloc(20, -1, -1, 711);
    bus.wb_valid = 1'b0;
    chk("bypass_ready", 32'(bus.issue_valid), 1);
    tick();
    chk("bypass_drain", 32'(exp_q.size()), 0);
    exp_q.push_back(720);
    bus.wb_valid = 1'b1;
    bus.wb_phys = 5;
    alloc(-1, -1, 5, 720);
    bus.wb_valid = 1'b0;
    alloc(5, -1, -1, 721);
    repeat (2) tick();
    chk("cos_waits", 32'(bus.issue_valid), 0);
    chk("cos_count", 32'(bus.count), 1);
    exp_q.push_back(721);
    wb(5);
    chk("cos_woken", 32'(bus.issue_valid), 1);
    tick();
    chk("cos_drain", 32'(exp_q.size()), 0);
    bus.issue_ready = 1'b0;
    for (int i = 0; i < IQ_DEPTH; i++) alloc(-1, -1, -1, 32'(100 + i));
    chk("full_count", 32'(bus.count), 16);
    chk("full_alloc_ready", 32'(bus.alloc_ready), 0);
    alloc(-1, -1, -1, 999);
    chk("full_drop", 32'(bus.count), 16);
    exp_q.push_back(100);
    bus.issue_ready = 1'b1;
    #1;
    chk("full_same_cycle", 32'(bus.alloc_ready), 0);
    tick();
    bus.issue_ready = 1'b0;
    chk("full_freed", 32'(bus.alloc_ready), 1);
    chk("full_count_dec", 32'(bus.count), 15);
    alloc(-1, -1, -1, 200);
    for (int i = 1; i < IQ_DEPTH; i++) exp_q.push_back(32'(100 + i));
    exp_q.push_back(200);
    bus.issue_ready = 1'b1;
    repeat (18) tick();
    chk("wrap_drain", 32'(exp_q.size()), 0);
    chk("wrap_count", 32'(bus.count), 0);
    bus.issue_ready = 1'b0;
    for (int i = 0; i < 7; i++) alloc(-1, -1, -1, 32'(300 + i));
    chk("flush_pre_count", 32'(bus.count), 7);
    bus.flush = 1'b1;
    bus.alloc_valid = 1'b1;
    bus.alloc_payload = 400;
    #1;
    chk("flush_alloc_ready", 32'(bus.alloc_ready), 0);
    tick();
    bus.flush = 1'b0;
    bus.alloc_valid = 1'b0;
    chk("flush_count", 32'(bus.count), 0);
    chk("flush_issue_valid", 32'(bus.issue_valid), 0);
    bus.issue_ready = 1'b1;
    repeat (3) tick();
    chk("flush_dropped", 32'(bus.issue_valid), 0);
    bus.issue_ready = 1'b0;
    alloc(-1, -1, 30, 500);
    alloc(-1, -1, 31, 501);
    alloc(-1, -1, -1, 502);
    rst = 1'b1;
    bus.alloc_valid = 1'b1;
    bus.issue_ready = 1'b1;
    tick();
    rst = 1'b0;
    bus.alloc_valid = 1'b0;
    chk("mrst_count", 32'(bus.count), 0);
    chk("mrst_issue_valid", 32'(bus.issue_valid), 0);
    chk("mrst_alloc_ready", 32'(bus.alloc_ready), 1);
    chk("mrst_payload", bus.issue_payload, 0);
    exp_q.push_back(600);
    alloc(30, 31, -1, 600);
    chk("mrst_sb_ready", 32'(bus.issue_valid), 1);
    tick();
    chk("mrst_drain", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
